univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal register: the next generation of the team's single-bit D flip-flop, widened to WIDTH bits. Per-cycle modes are hold, load, shift, rotate, arithmetic shift and clear. A multi-step shift engine with busy/done handshake applies a shift or rotate AMT times. Used as the general-purpose data register and serial/parallel converter in the lab datapaths.

Parameters:
WIDTH, 8, data width in bits (>=2)
AMT_W, 4, width of shift-amount input; must satisfy 2**AMT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  clock enable; 0 freezes all state except reset
op  in  3  operation: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR
din  in  WIDTH  parallel load data
sin  in  1  serial fill bit for SHL/SHR
start  in  1  begin multi-step shift of op by amt
amt  in  AMT_W  number of shift steps
q  out  WIDTH  register contents
sout  out  1  last bit shifted or rotated out
busy  out  1  multi-step operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high. While rst=1: q=0, sout=0, busy=0, done=0, state=IDLE, cnt=0. Reset mid-operation aborts the run and no done pulse follows.
- Single step definitions on q:
  - SHL: q<={q[W-2:0],sin}, sout<=q[W-1].
  - SHR: q<={sin,q[W-1:1]}, sout<=q[0].
  - ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
  - ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
  - ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0].
  - LOAD: q<=din. CLR: q<=0. HOLD: no change. sout is unchanged by LOAD, CLR and HOLD.
- done defaults to 0 every enabled edge; it is a one-cycle pulse.
- en=0: q, sout, busy, state and cnt all held. done is forced to 0 on that edge.
- IDLE, en=1, start=0: execute op once at this edge (1-cycle latency).
- IDLE, en=1, start=1, op in {SHL,SHR,ROL,ROR,ASR}:
  - amt=0: q unchanged, done<=1.
  - amt=1: one step, done<=1, stay IDLE.
  - amt>=2: one step, latch op into run_op, cnt<=amt-1, busy<=1, go to RUN.
- IDLE, start=1 with op not a shift/rotate: start is ignored and op executes as a single cycle.
- RUN, en=1: perform one run_op step (sin sampled live), cnt<=cnt-1. When cnt==1 at the edge: busy<=0, done<=1, go to IDLE. op, din, start and amt are ignored during RUN.
- Total latency: amt edges from the start edge to the final q. done and busy-fall coincide on the final edge. busy is high for amt-1 cycles.
- amt>WIDTH is legal; ROR/ROL wrap modulo WIDTH naturally through repeated steps.

Decomposition:
- Shared package: op encoding constants (OP_HOLD..OP_CLR), FSM state encoding (ST_IDLE, ST_RUN), and an is_shift_op function.
- Natural sub-module: shift_step, a combinational single-step datapath (inputs q, op, sin; outputs next_q, out_bit) instantiated once. The FSM and counter stay in the top module.

Test Plan:
- Assert rst mid-RUN (after LOAD 0xFF, start ROL amt=5, rst at step 2) -> q=0x00, busy=0, done=0 immediately, no later done pulse.
- LOAD 0xB4, then start SHL amt=3, sin=0 -> q 0x68, 0xD0, 0xA0 on successive edges; sout=1; busy high 2 cycles; done pulse on the 3rd edge.
- LOAD 0x90, start ASR amt=2 -> q=0xE4, sout=0, done after 2 edges. Also LOAD 0x81, start ROL amt=1 -> q=0x03, sout=1, busy never asserted.
- LOAD 0x5A, start ROR amt=8 -> q returns to 0x5A after 8 edges, busy high 7 cycles. Start with amt=0 -> q unchanged, done pulses next edge.
- During RUN (SHR amt=4 from 0xF0, sin=1) drop en for 2 cycles -> q, busy and cnt frozen, done=0. Resume -> final q=0xFF after 4 enabled steps.
- Single-cycle ops: LOAD 0x3C, SHR sin=1 -> 0x9E, CLR -> 0x00, HOLD -> 0x00. Also start=1 with op=LOAD -> plain load, done stays 0.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes,
// sequencer states and the shift/rotate classifier.
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ROL  = 3'd4,
      OP_ROR  = 3'd5,
      OP_ASR  = 3'd6,
      OP_CLR  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic logic is_shift_op(input logic [2:0] op);
      return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR};
   endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational single-step datapath: next register value and the bit
// pushed out by a shift or rotate.
module univ_shift_reg_shift_step
   import univ_shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [2:0]       op_i,
   input  logic             sin_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] next_q_o,
   output logic             out_bit_o
);

   always_comb begin
      next_q_o  = q_i;
      out_bit_o = 1'b0;
      case (op_e'(op_i))
         OP_LOAD: next_q_o = din_i;
         OP_SHL: begin
            next_q_o  = {q_i[WIDTH-2:0], sin_i};
            out_bit_o = q_i[WIDTH-1];
         end
         OP_SHR: begin
            next_q_o  = {sin_i, q_i[WIDTH-1:1]};
            out_bit_o = q_i[0];
         end
         OP_ROL: begin
            next_q_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            out_bit_o = q_i[WIDTH-1];
         end
         OP_ROR: begin
            next_q_o  = {q_i[0], q_i[WIDTH-1:1]};
            out_bit_o = q_i[0];
         end
         OP_ASR: begin
            next_q_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            out_bit_o = q_i[0];
         end
         OP_CLR:  next_q_o = '0;
         default: ;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register with per-cycle ops and a multi-step
// shift/rotate engine reporting busy/done.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic             sin,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

   state_e           state_q;
   op_e              run_op_q;
   logic [AMT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_q;
   logic             sout_q;
   logic             busy_q;
   logic             done_q;

   logic [2:0]       step_op_d;
   logic [WIDTH-1:0] step_q_d;
   logic             step_bit_d;

   // While running, the latched op drives the datapath; live op is ignored.
   assign step_op_d = (state_q == ST_RUN) ? run_op_q : op;

   univ_shift_reg_shift_step #(
      .WIDTH(WIDTH)
   ) u_shift_step (
      .q_i      (q_q),
      .op_i     (step_op_d),
      .sin_i    (sin),
      .din_i    (din),
      .next_q_o (step_q_d),
      .out_bit_o(step_bit_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         run_op_q <= OP_HOLD;
         cnt_q    <= '0;
         q_q      <= '0;
         sout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en) begin
            if (state_q == ST_RUN) begin
               q_q    <= step_q_d;
               sout_q <= step_bit_d;
               cnt_q  <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end else if (start && is_shift_op(op)) begin
               if (amt == '0) begin
                  done_q <= 1'b1;
               end else begin
                  q_q    <= step_q_d;
                  sout_q <= step_bit_d;
                  if (amt == CNT_ONE) begin
                     done_q <= 1'b1;
                  end else begin
                     run_op_q <= op_e'(op);
                     cnt_q    <= amt - CNT_ONE;
                     busy_q   <= 1'b1;
                     state_q  <= ST_RUN;
                  end
               end
            end else begin
               q_q <= step_q_d;
               if (is_shift_op(op)) sout_q <= step_bit_d;
            end
         end
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal expectations
// plus randomized traffic, all checked against a behavioural model.
module tb_univ_shift_reg;

   localparam int W    = 8;
   localparam int MASK = 255;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] din = 8'd0;
   logic       sin = 1'b0;
   logic       start = 1'b0;
   logic [3:0] amt = 4'd0;
   logic [7:0] q;
   logic       sout, busy, done;

   int vectors = 0;
   int miscompares = 0;

   // Literal expectations, set by the stimulus and checked at the next negedge.
   logic       exp_q_en = 1'b0, exp_f_en = 1'b0, exp_s_en = 1'b0;
   logic [7:0] exp_q = 8'd0;
   logic       exp_busy = 1'b0, exp_done = 1'b0, exp_sout = 1'b0;
   string      exp_nm = "";

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
      .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .sin(sin),
      .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done)
   );

   // Behavioural model: value arithmetic on ints plus a remaining-steps tally.
   int m_q = 0, m_sout = 0, m_left = 0, m_done = 0, m_rop = 0;

   function automatic bit shifty(input int o);
      return o >= 2 && o <= 6;
   endfunction

   function automatic int f_step(input int o, input int v, input int s, input int d);
      case (o)
         1: return d;
         2: return ((v << 1) | s) & MASK;
         3: return (v >> 1) | (s << (W - 1));
         4: return ((v << 1) | (v >> (W - 1))) & MASK;
         5: return (v >> 1) | ((v & 1) << (W - 1));
         6: return (v >> 1) | (v & (1 << (W - 1)));
         7: return 0;
         default: return v;
      endcase
   endfunction

   function automatic int f_out(input int o, input int v);
      return (o == 2 || o == 4) ? ((v >> (W - 1)) & 1) : (v & 1);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= 0; m_sout <= 0; m_left <= 0; m_done <= 0; m_rop <= 0;
      end else begin
         m_done <= 0;
         if (en) begin
            if (m_left != 0) begin
               m_q    <= f_step(m_rop, m_q, int'(sin), int'(din));
               m_sout <= f_out(m_rop, m_q);
               m_left <= m_left - 1;
               if (m_left == 1) m_done <= 1;
            end else if (start && shifty(int'(op))) begin
               if (amt == 0) begin
                  m_done <= 1;
               end else begin
                  m_q    <= f_step(int'(op), m_q, int'(sin), int'(din));
                  m_sout <= f_out(int'(op), m_q);
                  m_left <= int'(amt) - 1;
                  m_rop  <= int'(op);
                  if (amt == 1) m_done <= 1;
               end
            end else begin
               m_q <= f_step(int'(op), m_q, int'(sin), int'(din));
               if (shifty(int'(op))) m_sout <= f_out(int'(op), m_q);
            end
         end
      end
   end

   always @(negedge clk) begin
      vectors = vectors + 1;
      if (q !== 8'(m_q) || sout !== 1'(m_sout) || busy !== (m_left != 0) || done !== 1'(m_done)) begin
         miscompares = miscompares + 1;
         $display("FAIL model t=%0t q=%h sout=%b busy=%b done=%b expected q=%h sout=%0d busy=%0d done=%0d",
                  $time, q, sout, busy, done, m_q, m_sout, m_left != 0, m_done);
      end
      if (exp_q_en) begin
         vectors = vectors + 1;
         if (q !== exp_q) begin
            miscompares = miscompares + 1;
            $display("FAIL %s q got %h expected %h", exp_nm, q, exp_q);
         end
      end
      if (exp_f_en) begin
         vectors = vectors + 1;
         if (busy !== exp_busy || done !== exp_done) begin
            miscompares = miscompares + 1;
            $display("FAIL %s busy/done got %b/%b expected %b/%b", exp_nm, busy, done, exp_busy, exp_done);
         end
      end
      if (exp_s_en) begin
         vectors = vectors + 1;
         if (sout !== exp_sout) begin
            miscompares = miscompares + 1;
            $display("FAIL %s sout got %b expected %b", exp_nm, sout, exp_sout);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_q_en = 1'b0; exp_f_en = 1'b0; exp_s_en = 1'b0;
   endtask

   task automatic drive(input logic [2:0] o, input logic [7:0] d, input logic s,
                        input logic st, input logic [3:0] a);
      op = o; din = d; sin = s; start = st; amt = a;
   endtask

   task automatic ex(input string nm, input logic [7:0] vq, input logic b, input logic dn);
      exp_nm = nm; exp_q_en = 1'b1; exp_q = vq; exp_f_en = 1'b1; exp_busy = b; exp_done = dn;
   endtask

   task automatic ex_s(input logic s);
      exp_s_en = 1'b1; exp_sout = s;
   endtask

   initial begin
      tick(); tick();
      ex("reset", 8'h00, 1'b0, 1'b0); ex_s(1'b0);
      tick();
      rst = 1'b0; en = 1'b1;

      drive(3'd1, 8'h3C, 1'b0, 1'b0, 4'd0); tick(); ex("load3C", 8'h3C, 1'b0, 1'b0);
      drive(3'd3, 8'h00, 1'b1, 1'b0, 4'd0); tick(); ex("shr", 8'h9E, 1'b0, 1'b0); ex_s(1'b0);
      drive(3'd7, 8'h00, 1'b0, 1'b0, 4'd0); tick(); ex("clr", 8'h00, 1'b0, 1'b0);
      drive(3'd0, 8'h55, 1'b0, 1'b0, 4'd0); tick(); ex("hold", 8'h00, 1'b0, 1'b0);
      drive(3'd1, 8'h77, 1'b0, 1'b1, 4'd3); tick(); ex("start_load", 8'h77, 1'b0, 1'b0);
      drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick(); ex("start_load_after", 8'h77, 1'b0, 1'b0);

      drive(3'd1, 8'hB4, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd2, 8'h00, 1'b0, 1'b1, 4'd3); tick(); ex("shl1", 8'h68, 1'b1, 1'b0);
      drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick(); ex("shl2", 8'hD0, 1'b1, 1'b0);
      tick(); ex("shl3", 8'hA0, 1'b0, 1'b1); ex_s(1'b1);
      tick(); ex("shl_after", 8'hA0, 1'b0, 1'b0);

      drive(3'd1, 8'h90, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd6, 8'h00, 1'b0, 1'b1, 4'd2); tick(); ex("asr1", 8'hC8, 1'b1, 1'b0);
      drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick(); ex("asr2", 8'hE4, 1'b0, 1'b1); ex_s(1'b0);

      drive(3'd1, 8'h81, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd4, 8'h00, 1'b0, 1'b1, 4'd1); tick(); ex("rol1", 8'h03, 1'b0, 1'b1); ex_s(1'b1);

      drive(3'd1, 8'h5A, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd5, 8'h00, 1'b0, 1'b1, 4'd8); tick(); ex("ror8_busy", 8'h2D, 1'b1, 1'b0);
      drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0);
      for (int i = 0; i < 6; i++) begin
         tick(); exp_nm = "ror8_mid"; exp_f_en = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
      end
      tick(); ex("ror8_end", 8'h5A, 1'b0, 1'b1);
      drive(3'd5, 8'h00, 1'b0, 1'b1, 4'd0); tick(); ex("amt0", 8'h5A, 1'b0, 1'b1);

      drive(3'd1, 8'hF0, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd3, 8'h00, 1'b1, 1'b1, 4'd4); tick(); ex("shr_en1", 8'hF8, 1'b1, 1'b0);
      drive(3'd0, 8'h00, 1'b1, 1'b0, 4'd0); en = 1'b0;
      tick(); ex("freeze1", 8'hF8, 1'b1, 1'b0);
      tick(); ex("freeze2", 8'hF8, 1'b1, 1'b0);
      en = 1'b1;
      tick(); ex("shr_en2", 8'hFC, 1'b1, 1'b0);
      tick(); ex("shr_en3", 8'hFE, 1'b1, 1'b0);
      tick(); ex("shr_en4", 8'hFF, 1'b0, 1'b1);

      drive(3'd1, 8'hFF, 1'b0, 1'b0, 4'd0); tick();
      drive(3'd4, 8'h00, 1'b0, 1'b1, 4'd5); tick();
      drive(3'd0, 8'h00, 1'b0, 1'b0, 4'd0); tick();
      rst = 1'b1; ex("rst_mid", 8'h00, 1'b0, 1'b0); ex_s(1'b0);
      tick(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(); ex("no_late_done", 8'h00, 1'b0, 1'b0);
      end

      for (int i = 0; i < 1500; i++) begin
         tick();
         op    = 3'($urandom_range(0, 7));
         din   = 8'($urandom);
         sin   = 1'($urandom);
         start = ($urandom_range(0, 3) == 0);
         amt   = 4'($urandom_range(0, 15));
         en    = ($urandom_range(0, 7) != 0);
         rst   = ($urandom_range(0, 99) == 0);
      end
      tick(); rst = 1'b0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
